// File: rtl/bfnp_ctrl_pkg.sv
// Shared types and encodings for the BFNP RV32I multicycle control path.
// Holds the FSM state enum, immediate-select codes, instruction classes,
// opcode constants, PC/writeback mux encodings and the decode record.
package bfnp_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_FETCH_WAIT = 3'd1,
        S_DECODE     = 3'd2,
        S_EXEC       = 3'd3,
        S_MEM_REQ    = 3'd4,
        S_MEM_WAIT   = 3'd5,
        S_WB         = 3'd6,
        S_TRAP       = 3'd7
    } ctrl_state_e;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_SHAMT = 3'd2,
        IMM_S     = 3'd3,
        IMM_B     = 3'd4,
        IMM_U     = 3'd5,
        IMM_J     = 3'd6
    } imm_sel_e;

    // Sequencing class: decides the path taken after EXEC and the WB muxes.
    // LUI/AUIPC travel as CL_ALU.
    typedef enum logic [2:0] {
        CL_ALU    = 3'd0,
        CL_LOAD   = 3'd1,
        CL_STORE  = 3'd2,
        CL_BRANCH = 3'd3,
        CL_JAL    = 3'd4,
        CL_JALR   = 3'd5
    } instr_class_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SEL_IMM   = 2'd1;
    localparam logic [1:0] PC_SEL_ALU   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;

    typedef struct packed {
        imm_sel_e     imm_sel;
        logic [3:0]   alu_op;
        logic         a_sel;
        logic         b_sel;
        instr_class_e cls;
        logic         legal;
    } decode_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder for the multicycle controller.
// Ports:
//   instr_i  in  32  instruction register contents
//   dec_o    out     {imm_sel, alu_op, a_sel, b_sel, class, legal}
// Illegal opcodes return an all-zero record with legal=0.
module ctrl_decode
    import bfnp_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output decode_t     dec_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic       unused_instr;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign f7b5   = instr_i[30];
    // Register and immediate fields are consumed by the datapath, not here.
    assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

    always_comb begin
        dec_o         = '0;
        dec_o.imm_sel = IMM_NONE;
        dec_o.cls     = CL_ALU;
        dec_o.legal   = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec_o.alu_op = {f7b5, funct3};
            end
            OPC_OP_IMM: begin
                dec_o.b_sel = 1'b1;
                // Shifts keep funct7[5] to tell SRLI from SRAI; other
                // OP-IMM ops have immediate bits there, so it is dropped.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_o.imm_sel = IMM_SHAMT;
                    dec_o.alu_op  = {f7b5, funct3};
                end else begin
                    dec_o.imm_sel = IMM_I;
                    dec_o.alu_op  = {1'b0, funct3};
                end
            end
            OPC_LOAD: begin
                dec_o.imm_sel = IMM_I;
                dec_o.b_sel   = 1'b1;
                dec_o.cls     = CL_LOAD;
            end
            OPC_STORE: begin
                dec_o.imm_sel = IMM_S;
                dec_o.b_sel   = 1'b1;
                dec_o.cls     = CL_STORE;
            end
            OPC_BRANCH: begin
                // ALU compares rs1/rs2; the target comes from the PC+imm path.
                dec_o.imm_sel = IMM_B;
                dec_o.cls     = CL_BRANCH;
            end
            OPC_LUI: begin
                dec_o.imm_sel = IMM_U;
                dec_o.b_sel   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_o.imm_sel = IMM_U;
                dec_o.a_sel   = 1'b1;
                dec_o.b_sel   = 1'b1;
            end
            OPC_JAL: begin
                dec_o.imm_sel = IMM_J;
                dec_o.b_sel   = 1'b1;
                dec_o.cls     = CL_JAL;
            end
            OPC_JALR: begin
                dec_o.imm_sel = IMM_I;
                dec_o.b_sel   = 1'b1;
                dec_o.cls     = CL_JALR;
            end
            default: begin
                dec_o.legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the BFNP RV32I core. Sequences fetch, decode,
// execute, memory and writeback over one shared datapath and a single
// req/gnt/rvalid memory port, and counts retired instructions.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   instr                 instruction register contents
//   branch_taken          ALU compare result (valid in EXEC)
//   mem_gnt, mem_rvalid   memory handshake inputs
//   mem_req, mem_we, mem_addr_sel        memory request outputs
//   ir_we, pc_we, reg_we                 one-cycle datapath write pulses
//   pc_sel, wb_sel                       PC / writeback mux selects
//   alu_a_sel, alu_b_sel, alu_op, imm_sel decode results held to retirement
//   illegal                              sticky illegal-opcode flag
//   instret                              retired count, wraps
module multicycle_ctrl
    import bfnp_ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          instr,
    input  logic                 branch_taken,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_addr_sel,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_sel,
    output logic                 reg_we,
    output logic [1:0]           wb_sel,
    output logic                 alu_a_sel,
    output logic                 alu_b_sel,
    output logic [3:0]           alu_op,
    output logic [2:0]           imm_sel,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    ctrl_state_e            state_q, state_d;
    decode_t                dec;
    imm_sel_e               imm_sel_q;
    logic [3:0]             alu_op_q;
    logic                   a_sel_q, b_sel_q;
    instr_class_e           cls_q;
    logic                   illegal_q;
    logic [INSTRET_W-1:0]   instret_q;
    logic                   retire;

    ctrl_decode u_decode (
        .instr_i (instr),
        .dec_o   (dec)
    );

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_SEL_PLUS4;
        reg_we       = 1'b0;
        wb_sel       = WB_SEL_ALU;
        retire       = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_gnt) state_d = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                if (mem_rvalid) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = dec.legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                case (cls_q)
                    CL_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    CL_LOAD, CL_STORE: state_d = S_MEM_REQ;
                    default:           state_d = S_WB;
                endcase
            end
            S_MEM_REQ: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (cls_q == CL_STORE);
                if (mem_gnt) state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (mem_rvalid) begin
                    if (cls_q == CL_STORE) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
                case (cls_q)
                    CL_LOAD: wb_sel = WB_SEL_LOAD;
                    CL_JAL: begin
                        wb_sel = WB_SEL_PC4;
                        pc_sel = PC_SEL_IMM;
                    end
                    CL_JALR: begin
                        wb_sel = WB_SEL_PC4;
                        pc_sel = PC_SEL_ALU;
                    end
                    default: ;
                endcase
            end
            default: ; // S_TRAP: parked until reset
        endcase
        // The reset state is FETCH, which would otherwise request; force the
        // port quiet while reset is held so a cut transaction drops at once.
        if (!rst_n) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
            retire  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            imm_sel_q <= IMM_NONE;
            alu_op_q  <= '0;
            a_sel_q   <= 1'b0;
            b_sel_q   <= 1'b0;
            cls_q     <= CL_ALU;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                imm_sel_q <= dec.imm_sel;
                alu_op_q  <= dec.alu_op;
                a_sel_q   <= dec.a_sel;
                b_sel_q   <= dec.b_sel;
                cls_q     <= dec.cls;
            end
            if (state_d == S_TRAP) illegal_q <= 1'b1;
            if (retire) instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    assign imm_sel   = imm_sel_q;
    assign alu_op    = alu_op_q;
    assign alu_a_sel = a_sel_q;
    assign alu_b_sel = b_sel_q;
    assign illegal   = illegal_q;
    assign instret   = instret_q;

endmodule
